// File: rtl/rd_pipe_subtractor.sv
// rd_pipe_subtractor
//   Pipelined recursive-doubling (Kogge-Stone) subtractor: diff = a - b - bin.
//   Computed as a + ~b + ~bin. Every prefix level sits behind its own register
//   stage, so the depth is LOG_W+2 stages and there is no combinational path
//   from the inputs to the outputs. All stages move together under a single
//   enable, en = ~out_valid | out_ready. A stalled result is held until it is
//   accepted.
//
//   Optional feature: define RD_OVF_EN to add the ovf port (signed overflow).
//   This also adds a small sign-bit pipeline that runs in step with the data.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/bin valid
//   in_ready   block accepts operands (depends only on out_valid/out_ready)
//   a, b       minuend / subtrahend, bit-indexed [WIDTH:1], bit 1 = LSB
//   bin        borrow in
//   out_valid  diff/bout valid
//   out_ready  downstream accepts the result
//   diff       a - b - bin mod 2^WIDTH
//   bout       1 iff a < b + bin (unsigned)
//   ovf        signed overflow (RD_OVF_EN only)
`timescale 1ns/1ps

module rd_pipe_subtractor #(
  parameter int WIDTH = 32,
  parameter int LOG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:1] a,
  input  logic [WIDTH:1] b,
  input  logic           bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:1] diff,
  output logic           bout
`ifdef RD_OVF_EN
  ,
  output logic           ovf
`endif
);

  logic en;

  // Stage k holds the group generate/propagate after k doubling levels.
  // The last level needs no propagate, so p has one stage fewer.
  logic [WIDTH:1] g_q  [0:LOG_W];
  logic [WIDTH:1] g_d  [0:LOG_W];
  logic [WIDTH:1] p_q  [0:LOG_W-1];
  logic [WIDTH:1] p_d  [0:LOG_W-1];
  logic [WIDTH:1] pc_q [0:LOG_W];   // untouched bit propagate, used for the sum
  logic [WIDTH:1] pc_d [0:LOG_W];
  logic           c0_q [0:LOG_W];
  logic           c0_d [0:LOG_W];
  logic           v_q  [0:LOG_W];
  logic           v_d  [0:LOG_W];

  logic [WIDTH:1] diff_q, diff_d;
  logic           bout_q, bout_d;
  logic           out_valid_q, out_valid_d;

  logic [WIDTH:1] g0, p0, cin_vec;

`ifdef RD_OVF_EN
  logic sx_q [0:LOG_W];   // operand signs differ
  logic sx_d [0:LOG_W];
  logic sa_q [0:LOG_W];   // sign of a
  logic sa_d [0:LOG_W];
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    en = ~out_valid_q | out_ready;

    // S0: bitwise generate/propagate of a + ~b.
    g0 = a & ~b;
    p0 = ~(a ^ b);
    g_d[0]    = g0;
    // Fold the carry-in into bit 1. After that, the group generate over
    // [1..i] is exactly the carry out of bit i. This means LOG_W levels are
    // enough to reach c_WIDTH.
    g_d[0][1] = g0[1] | (p0[1] & ~bin);
    p_d[0]    = p0;
    pc_d[0]   = p0;
    c0_d[0]   = ~bin;
    v_d[0]    = in_valid;

    // S1..S_LOG_W: one doubling level each. Bits at or below the span pass through.
    for (int k = 1; k <= LOG_W; k++) begin
      g_d[k]  = g_q[k-1];
      pc_d[k] = pc_q[k-1];
      c0_d[k] = c0_q[k-1];
      v_d[k]  = v_q[k-1];
      for (int i = 1; i <= WIDTH; i++) begin
        if (i > (1 << (k - 1))) begin
          g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
        end
      end
    end
    for (int k = 1; k < LOG_W; k++) begin
      p_d[k] = p_q[k-1];
      for (int i = 1; i <= WIDTH; i++) begin
        if (i > (1 << (k - 1))) begin
          p_d[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k - 1))];
        end
      end
    end

    // S_OUT: the carry into bit i is c_(i-1). Borrow is the inverted final carry.
    cin_vec     = {g_q[LOG_W][WIDTH-1:1], c0_q[LOG_W]};
    diff_d      = pc_q[LOG_W] ^ cin_vec;
    bout_d      = ~g_q[LOG_W][WIDTH];
    out_valid_d = v_q[LOG_W];

`ifdef RD_OVF_EN
    sx_d[0] = a[WIDTH] ^ b[WIDTH];
    sa_d[0] = a[WIDTH];
    for (int k = 1; k <= LOG_W; k++) begin
      sx_d[k] = sx_q[k-1];
      sa_d[k] = sa_q[k-1];
    end
    ovf_d = sx_q[LOG_W] & (diff_d[WIDTH] ^ sa_q[LOG_W]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LOG_W; k++) begin
        g_q[k]  <= '0;
        pc_q[k] <= '0;
        c0_q[k] <= 1'b0;
        v_q[k]  <= 1'b0;
      end
      for (int k = 0; k < LOG_W; k++) begin
        p_q[k] <= '0;
      end
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef RD_OVF_EN
      for (int k = 0; k <= LOG_W; k++) begin
        sx_q[k] <= 1'b0;
        sa_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
`endif
    end else if (en) begin
      for (int k = 0; k <= LOG_W; k++) begin
        g_q[k]  <= g_d[k];
        pc_q[k] <= pc_d[k];
        c0_q[k] <= c0_d[k];
        v_q[k]  <= v_d[k];
      end
      for (int k = 0; k < LOG_W; k++) begin
        p_q[k] <= p_d[k];
      end
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
`ifdef RD_OVF_EN
      for (int k = 0; k <= LOG_W; k++) begin
        sx_q[k] <= sx_d[k];
        sa_q[k] <= sa_d[k];
      end
      ovf_q <= ovf_d;
`endif
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef RD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rd_pipe_subtractor.sv
// Testbench for rd_pipe_subtractor: directed vectors with hand-computed
// results, reset mid-stream, backpressure and a randomised handshake run
// against a reference model. Build with +define+RD_OVF_EN to cover ovf.
`timescale 1ns/1ps

module tb_rd_pipe_subtractor;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W:1]   a = '0;
  logic [W:1]   b = '0;
  logic         in_ready, out_valid, bout;
  logic [W:1]   diff;
`ifdef RD_OVF_EN
  logic         ovf;
`endif

  rd_pipe_subtractor #(.WIDTH(W), .LOG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef RD_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W:1]  d;
    logic        bo;
    logic        ov;
    logic [31:0] acc;   // edge at which the operands were accepted
  } exp_t;

  exp_t       exp_q[$];
  exp_t       hand;
  int         tests = 0, fails = 0;
  int         nin = 0, nout = 0, cyc = 0, last_lat = -1, ov_seen = 0;
  bit         verbose = 1'b1, hand_en = 1'b0, chk_lat = 1'b0;
  bit         stall_prev = 1'b0;
  logic [W:1] diff_prev = '0;
  logic       bout_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W:1] aa, input logic [W:1] bb, input logic bi);
    logic [W+1:1] r;
    exp_t e;
    r = {1'b0, aa} - {1'b0, bb} - {{W{1'b0}}, bi};
    e.d   = r[W:1];
    e.bo  = r[W+1];
    e.ov  = (aa[W] ^ bb[W]) & (r[W] ^ aa[W]);
    e.acc = '0;
    return e;
  endfunction

  // One clock cycle. It is entered at a negedge with the inputs already driven.
  // It checks handshake and outputs, records transfers, and returns at the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    chk("in_ready", in_ready, (!out_valid || out_ready));
    if (out_valid) ov_seen++;
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_diff", diff, diff_prev);
      chk("hold_bout", bout, bout_prev);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("diff", diff, e.d);
        chk("bout", bout, e.bo);
`ifdef RD_OVF_EN
        chk("ovf", ovf, e.ov);
`endif
        last_lat = cyc - int'(e.acc);
        if (chk_lat) chk("latency", last_lat, 6);
        nout++;
        if (verbose) $display("[TB] out diff=%h bout=%b lat=%0d", diff, bout, last_lat);
      end
    end
    if (in_valid && in_ready) begin
      e = hand_en ? hand : model(a, b, bin);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      nin++;
      if (verbose) $display("[TB] in  a=%h b=%h bin=%b", a, b, bin);
    end
    stall_prev = out_valid && !out_ready;
    diff_prev  = diff;
    bout_prev  = bout;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Directed op with hand-computed expected result; issued for one cycle.
  task automatic op(input logic [W:1] aa, input logic [W:1] bb, input logic bi,
                    input logic [W:1] ed, input logic ebo, input logic eov);
    a = aa; b = bb; bin = bi; in_valid = 1'b1;
    hand.d = ed; hand.bo = ebo; hand.ov = eov; hand.acc = '0;
    hand_en = 1'b1;
    tick();
    hand_en = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int seen, n0, nin0, guard;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_diff", diff, '0);
    chk("rst_bout", bout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset with three ops in flight, the first one stalled at the output
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'd100 + i; b = 32'd7; bin = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("t1_reach_out", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", out_valid, 1'b0);
    chk("t1_in_ready", in_ready, 1'b1);
    chk("t1_diff", diff, '0);
    chk("t1_bout", bout, 1'b0);
    exp_q.delete();
    nin = nout;
    stall_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    ov_seen = 0;
    repeat (15) tick();
    chk("t1_no_ghost", ov_seen, 0);

    // 2: single op, latency and single-cycle out_valid
    chk_lat = 1'b1;
    ov_seen = 0;
    op(32'hF8E38E38, 32'hF8E381DB, 1'b0, 32'h00000C5D, 1'b0, 1'b0);
    repeat (10) tick();
    chk("t2_pulse", ov_seen, 1);
    chk("t2_lat", last_lat, 6);

    // 3: wrap-around; 4: signed overflow
    op(32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    op(32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    op(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);
    op(32'h12345678, 32'h02345678, 1'b1, 32'h0FFFFFFF, 1'b0, 1'b0);
    repeat (10) tick();
    chk("t34_count", nout, nin);
    chk_lat = 1'b0;

    // 5: back-to-back ops with out_ready low for cycles 8..12
    n0 = nout;
    begin
      int i;
      i = 0;
      for (int c = 0; c < 40; c++) begin
        out_ready = !(c >= 8 && c <= 12);
        if (i < 10) begin
          in_valid = 1'b1; a = i * 1000; b = i; bin = i[0];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (c >= 8 && c <= 12) chk("t5_in_ready_low", in_ready, 1'b0);
        nin0 = nin;
        tick();
        if (nin != nin0) i++;
      end
      in_valid = 1'b0;
    end
    chk("t5_count", nout - n0, 10);

    // 6: random handshake
    verbose = 1'b0;
    nin0 = nin;
    guard = 0;
    while ((nin - nin0) < 10000 && guard < 60000) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid) begin
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      end else begin
        a = 'x; b = 'x; bin = 1'bx;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    chk("t6_in_count", nin - nin0, 10000);
    chk("t6_io_count", nout, nin);
    chk("t6_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
